// File: rtl/oh_pkg.sv
// -----------------------------------------------------------------------------
// oh_pkg
// Shared types and constants for the one-hot select driver family.
//   oh_sel_state_t : driver FSM states (idle, driving a select, break gap)
//   OH_DIR_LSB0    : index 0 maps to bit 0
//   OH_DIR_MSB0    : index 0 maps to bit NUM_SIGNALS-1
// -----------------------------------------------------------------------------
package oh_pkg;

  typedef enum logic [1:0] {
    OHS_IDLE,
    OHS_DRIVE,
    OHS_GAP
  } oh_sel_state_t;

  localparam OH_DIR_LSB0 = "LSB0";
  localparam OH_DIR_MSB0 = "MSB0";

  // Index width for a given one-hot width, never below one bit.
  function automatic int oh_index_width(input int num_signals);
    return (num_signals > 1) ? $clog2(num_signals) : 1;
  endfunction

endpackage

// File: rtl/idx_to_oh.sv
// -----------------------------------------------------------------------------
// idx_to_oh
// Purely combinational binary index to one-hot decoder.
// Parameters:
//   NUM_SIGNALS : width of the one-hot output
//   DIRECTION   : OH_DIR_LSB0 or OH_DIR_MSB0 bit ordering
// Ports:
//   index_i   : binary index
//   one_hot_o : exactly one bit set for index_i < NUM_SIGNALS, else all-zero
// -----------------------------------------------------------------------------
module idx_to_oh
  import oh_pkg::*;
#(
  parameter int NUM_SIGNALS = 4,
  parameter     DIRECTION   = OH_DIR_LSB0,
  localparam int INDEX_WIDTH = oh_index_width(NUM_SIGNALS)
) (
  input  logic [INDEX_WIDTH-1:0] index_i,
  output logic [NUM_SIGNALS-1:0] one_hot_o
);

  localparam bit MSB0 = (DIRECTION == OH_DIR_MSB0);

  // Indices that match no bit position leave the output all-zero.
  always_comb begin
    one_hot_o = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (index_i == INDEX_WIDTH'(i)) begin
        one_hot_o[MSB0 ? (NUM_SIGNALS - 1 - i) : i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oh_sel_driver.sv
// -----------------------------------------------------------------------------
// oh_sel_driver
// Accepts binary index commands over valid/ready and drives a registered,
// glitch-free one-hot select bus for a programmable dwell, followed by an
// all-zero break-before-make gap of GAP_CYCLES cycles.
//
// Optional feature (compile-time macro OH_SEL_DRIVER_RANGE_CHK_EN):
//   defined   : an accepted index >= NUM_SIGNALS is dropped and sets the sticky
//               err_oor flag; a simulation assertion reports it.
//   undefined : err_oor is tied low; an out-of-range index drives all-zero
//               for its dwell while oh_valid still asserts.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : command valid
//   in_ready  : command accepted when in_valid && in_ready (combinational)
//   in_index  : binary index to select
//   in_dwell  : cycles to hold the select (0 behaves as 1)
//   one_hot   : registered one-hot select, zero when idle or in gap
//   oh_valid  : high while in the DRIVE state
//   busy      : high in DRIVE or GAP
//   err_oor   : sticky out-of-range error
// -----------------------------------------------------------------------------
module oh_sel_driver
  import oh_pkg::*;
#(
  parameter int NUM_SIGNALS = 4,
  parameter     DIRECTION   = OH_DIR_LSB0,
  parameter int DWELL_WIDTH = 8,
  parameter int GAP_CYCLES  = 1,
  localparam int INDEX_WIDTH = oh_index_width(NUM_SIGNALS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INDEX_WIDTH-1:0] in_index,
  input  logic [DWELL_WIDTH-1:0] in_dwell,
  output logic [NUM_SIGNALS-1:0] one_hot,
  output logic                   oh_valid,
  output logic                   busy,
  output logic                   err_oor
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  oh_sel_state_t          state_q, state_d;
  logic [NUM_SIGNALS-1:0] one_hot_q, one_hot_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [GAP_W-1:0]       gap_q, gap_d;

  logic [NUM_SIGNALS-1:0] dec_oh;
  logic [DWELL_WIDTH-1:0] dwell_ld;
  logic                   last_drive;
  logic                   accept;

  // Decoder sits ahead of the one_hot register, so the bus never sees
  // decoder glitches.
  idx_to_oh #(
    .NUM_SIGNALS (NUM_SIGNALS),
    .DIRECTION   (DIRECTION)
  ) u_dec (
    .index_i   (in_index),
    .one_hot_o (dec_oh)
  );

  // A dwell of zero is held for one cycle, same as a dwell of one.
  assign dwell_ld = (in_dwell == '0) ? '0 : (in_dwell - DWELL_WIDTH'(1));

  assign last_drive = (state_q == OHS_DRIVE) && (dwell_q == '0);

  // Without a gap, the final drive cycle can take the next command so the
  // new select follows directly with no zero cycle.
  assign in_ready = (state_q == OHS_IDLE) || (last_drive && (GAP_CYCLES == 0));
  assign accept   = in_valid && in_ready;

`ifdef OH_SEL_DRIVER_RANGE_CHK_EN
  logic oor;
  logic err_q, err_d;

  assign oor = ({1'b0, in_index} >= (INDEX_WIDTH + 1)'(NUM_SIGNALS));
`endif

  always_comb begin
    state_d   = state_q;
    one_hot_d = one_hot_q;
    dwell_d   = dwell_q;
    gap_d     = gap_q;
    unique case (state_q)
      OHS_IDLE: begin
        if (accept) begin
          state_d   = OHS_DRIVE;
          one_hot_d = dec_oh;
          dwell_d   = dwell_ld;
        end
      end
      OHS_DRIVE: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_WIDTH'(1);
        end else if (GAP_CYCLES > 0) begin
          state_d   = OHS_GAP;
          one_hot_d = '0;
          gap_d     = GAP_W'(GAP_CYCLES - 1);
        end else if (accept) begin
          state_d   = OHS_DRIVE;
          one_hot_d = dec_oh;
          dwell_d   = dwell_ld;
        end else begin
          state_d   = OHS_IDLE;
          one_hot_d = '0;
        end
      end
      OHS_GAP: begin
        if (gap_q == '0) begin
          state_d = OHS_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d   = OHS_IDLE;
        one_hot_d = '0;
      end
    endcase
`ifdef OH_SEL_DRIVER_RANGE_CHK_EN
    err_d = err_q;
    // An out-of-range command is dropped entirely; any select that was
    // finishing its dwell is released.
    if (accept && oor) begin
      state_d   = OHS_IDLE;
      one_hot_d = '0;
      dwell_d   = '0;
      err_d     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OHS_IDLE;
      one_hot_q <= '0;
      dwell_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      one_hot_q <= one_hot_d;
      dwell_q   <= dwell_d;
      gap_q     <= gap_d;
    end
  end

`ifdef OH_SEL_DRIVER_RANGE_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_oor = err_q;

  a_index_in_range: assert property (
    @(posedge clk) disable iff (!rst_n) !(accept && oor)
  ) else $warning("oh_sel_driver: out-of-range index command dropped");
`else
  assign err_oor = 1'b0;
`endif

  assign one_hot  = one_hot_q;
  assign oh_valid = (state_q == OHS_DRIVE);
  assign busy     = (state_q != OHS_IDLE);

endmodule

// File: tb/tb_oh_sel_driver.sv
// -----------------------------------------------------------------------------
// tb_oh_sel_driver
// Four driver instances share clock, reset, index and dwell; each has its own
// valid so only one is commanded at a time:
//   0: 4 signals, LSB0, gap 1    1: 4 signals, MSB0, gap 1
//   2: 4 signals, LSB0, gap 0    3: 5 signals, LSB0, gap 1
// -----------------------------------------------------------------------------
module tb_oh_sel_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] vld;
  logic [2:0] idx;
  logic [7:0] dwell;

  logic [3:0] rdy, ohv, bsy, err;
  logic [3:0] oh0, oh1, oh2;
  logic [4:0] oh3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  oh_sel_driver #(.NUM_SIGNALS(4), .DIRECTION("LSB0"), .DWELL_WIDTH(8), .GAP_CYCLES(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_index(idx[1:0]),
    .in_dwell(dwell), .one_hot(oh0), .oh_valid(ohv[0]), .busy(bsy[0]), .err_oor(err[0]));

  oh_sel_driver #(.NUM_SIGNALS(4), .DIRECTION("MSB0"), .DWELL_WIDTH(8), .GAP_CYCLES(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_index(idx[1:0]),
    .in_dwell(dwell), .one_hot(oh1), .oh_valid(ohv[1]), .busy(bsy[1]), .err_oor(err[1]));

  oh_sel_driver #(.NUM_SIGNALS(4), .DIRECTION("LSB0"), .DWELL_WIDTH(8), .GAP_CYCLES(0)) u_b2b (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_index(idx[1:0]),
    .in_dwell(dwell), .one_hot(oh2), .oh_valid(ohv[2]), .busy(bsy[2]), .err_oor(err[2]));

  oh_sel_driver #(.NUM_SIGNALS(5), .DIRECTION("LSB0"), .DWELL_WIDTH(8), .GAP_CYCLES(1)) u_oor (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[3]), .in_ready(rdy[3]), .in_index(idx),
    .in_dwell(dwell), .one_hot(oh3), .oh_valid(ohv[3]), .busy(bsy[3]), .err_oor(err[3]));

  typedef struct {
    int sel;
    int index;
    int dwell;
    int exp_oh;
    int len;
  } vec_t;

  vec_t tbl[$];

  function automatic int f_oh(input int s);
    case (s)
      0:       return int'(oh0);
      1:       return int'(oh1);
      2:       return int'(oh2);
      default: return int'(oh3);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int s);
    for (int i = 0; i < 400 && !rdy[s]; i++) next_cyc();
    chk("ready_wait", int'(rdy[s]), 1);
  endtask

  // Issue one command and follow it through dwell, gap and return to idle.
  task automatic run_cmd(input int s, input int i, input int d, input int exp, input int len);
    wait_ready(s);
    idx    = 3'(i);
    dwell  = 8'(d);
    vld[s] = 1'b1;
    next_cyc();
    vld[s] = 1'b0;
    for (int k = 0; k < len; k++) begin
      chk("drive_oh", f_oh(s), exp);
      chk("drive_oh_valid", int'(ohv[s]), 1);
      chk("drive_ready", int'(rdy[s]), 0);
      next_cyc();
    end
    chk("gap_oh", f_oh(s), 0);
    chk("gap_oh_valid", int'(ohv[s]), 0);
    chk("gap_busy", int'(bsy[s]), 1);
    chk("gap_ready", int'(rdy[s]), 0);
    next_cyc();
    chk("idle_ready", int'(rdy[s]), 1);
    chk("idle_busy", int'(bsy[s]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{0, 2,   3, 'b0100, 3});
    tbl.push_back('{0, 0,   1, 'b0001, 1});
    tbl.push_back('{0, 3,   0, 'b1000, 1});
    tbl.push_back('{0, 1,   5, 'b0010, 5});
    tbl.push_back('{0, 1, 255, 'b0010, 255});
    tbl.push_back('{1, 0,   0, 'b1000, 1});
    tbl.push_back('{1, 3,   2, 'b0001, 2});
    tbl.push_back('{1, 1,   1, 'b0100, 1});
    tbl.push_back('{1, 2,   4, 'b0010, 4});
    tbl.push_back('{3, 4,   1, 'b10000, 1});
    tbl.push_back('{3, 0,   2, 'b00001, 2});
`ifndef OH_SEL_DRIVER_RANGE_CHK_EN
    tbl.push_back('{3, 6,   2, 'b00000, 2});
`endif

    rst_n = 1'b0;
    vld   = '0;
    idx   = '0;
    dwell = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      chk("rst_oh", f_oh(s), 0);
      chk("rst_oh_valid", int'(ohv[s]), 0);
      chk("rst_busy", int'(bsy[s]), 0);
      chk("rst_ready", int'(rdy[s]), 1);
      chk("rst_err", int'(err[s]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();

    foreach (tbl[n]) begin
      run_cmd(tbl[n].sel, tbl[n].index, tbl[n].dwell, tbl[n].exp_oh, tbl[n].len);
    end
    chk("oor_err_after_table", int'(err[3]), 0);

    // Back-to-back without gap: 1 then 3, dwell 2, valid held throughout.
    wait_ready(2);
    idx    = 3'd1;
    dwell  = 8'd2;
    vld[2] = 1'b1;
    next_cyc();
    idx = 3'd3;
    chk("b2b_c1_oh", f_oh(2), 'b0010);
    chk("b2b_c1_ready", int'(rdy[2]), 0);
    next_cyc();
    chk("b2b_c2_oh", f_oh(2), 'b0010);
    chk("b2b_c2_ready", int'(rdy[2]), 1);
    next_cyc();
    vld[2] = 1'b0;
    chk("b2b_c3_oh", f_oh(2), 'b1000);
    chk("b2b_c3_oh_valid", int'(ohv[2]), 1);
    chk("b2b_c3_ready", int'(rdy[2]), 0);
    next_cyc();
    chk("b2b_c4_oh", f_oh(2), 'b1000);
    chk("b2b_c4_ready", int'(rdy[2]), 1);
    next_cyc();
    chk("b2b_end_oh", f_oh(2), 0);
    chk("b2b_end_oh_valid", int'(ohv[2]), 0);
    chk("b2b_end_busy", int'(bsy[2]), 0);

`ifdef OH_SEL_DRIVER_RANGE_CHK_EN
    // Out-of-range command is dropped and flags a sticky error.
    wait_ready(3);
    idx    = 3'd6;
    dwell  = 8'd2;
    vld[3] = 1'b1;
    next_cyc();
    vld[3] = 1'b0;
    chk("oor_err", int'(err[3]), 1);
    chk("oor_oh", f_oh(3), 0);
    chk("oor_oh_valid", int'(ohv[3]), 0);
    chk("oor_busy", int'(bsy[3]), 0);
    chk("oor_ready", int'(rdy[3]), 1);
    run_cmd(3, 2, 1, 'b00100, 1);
    chk("oor_err_sticky", int'(err[3]), 1);
`endif

    // Asynchronous reset in the middle of a long dwell.
    wait_ready(0);
    idx    = 3'd1;
    dwell  = 8'd10;
    vld[0] = 1'b1;
    next_cyc();
    repeat (3) next_cyc();
    chk("mid_drive_oh", f_oh(0), 'b0010);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_oh", f_oh(0), 0);
    chk("async_rst_oh_valid", int'(ohv[0]), 0);
    chk("async_rst_busy", int'(bsy[0]), 0);
    next_cyc();
    chk("in_rst_no_accept_oh", f_oh(0), 0);
    chk("in_rst_no_accept_busy", int'(bsy[0]), 0);
    vld[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    chk("post_rst_busy", int'(bsy[0]), 0);
    chk("post_rst_ready", int'(rdy[0]), 1);
    chk("post_rst_err", int'(err[3]), 0);
    run_cmd(0, 3, 1, 'b1000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oh_sel_driver.md
Name: oh_sel_driver

Overview:
- Inverse of the codebase's one-hot→index encoder. Accepts binary index commands over a valid/ready handshake and drives a registered one-hot select bus for a programmable dwell time.
- Inserts a break-before-make gap between consecutive selects.
- Sits in front of mux/crossbar select lines, analog switch enables and round-robin-driven banks, where glitch-free, non-overlapping one-hot selects are required.

Parameters:
- NUM_SIGNALS, 4: width of the one-hot output.
- DIRECTION, "LSB0": "LSB0" means index 0 drives bit 0; "MSB0" means index 0 drives bit NUM_SIGNALS-1.
- DWELL_WIDTH, 8: width of the dwell-count input.
- GAP_CYCLES, 1: all-zero cycles inserted after each dwell; 0 is legal.
- INDEX_WIDTH (localparam): $clog2(NUM_SIGNALS), minimum 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_index  in  INDEX_WIDTH  binary index to select
- in_dwell  in  DWELL_WIDTH  number of cycles to hold the select; 0 is treated as 1
- one_hot  out  NUM_SIGNALS  registered one-hot select; all-zero when idle or in gap
- oh_valid  out  1  high exactly while one_hot is non-zero-by-command (DRIVE state)
- busy  out  1  high in DRIVE or GAP
- err_oor  out  1  sticky out-of-range error (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst_n is asynchronous assert, active-low.
- Reset values: state=IDLE, one_hot='0, oh_valid=0, busy=0, err_oor=0, dwell counter=0, gap counter=0. in_ready is combinational and equals 1 in IDLE.
- All outputs except in_ready are registered. No combinational path exists from in_* to one_hot.
- States: IDLE, DRIVE, GAP.
- IDLE:
  - in_ready=1.
  - On accept at edge T: one_hot ← decode(in_index, DIRECTION); dwell_cnt ← max(in_dwell,1)-1; go to DRIVE.
  - one_hot becomes visible in the cycle after T (latency 1).
- DRIVE:
  - oh_valid=1; one_hot held stable.
  - dwell_cnt decrements each cycle.
  - At dwell_cnt==0: if GAP_CYCLES>0, one_hot←0, gap_cnt←GAP_CYCLES-1, go to GAP; else go to IDLE.
  - in_ready=0, except in the last DRIVE cycle when GAP_CYCLES==0.
  - Back-to-back case (GAP_CYCLES==0): an accept in the last DRIVE cycle loads the new select directly and stays in DRIVE, with no zero cycle.
- GAP:
  - one_hot='0, oh_valid=0, in_ready=0.
  - gap_cnt decrements; at 0, go to IDLE.
- Throughput: one command per (dwell + GAP_CYCLES + 1) cycles, or per dwell cycles when GAP_CYCLES==0.
- Maximum dwell: 2^DWELL_WIDTH-1. The counter never wraps.
- Decode: exactly one bit set for in-range indices. Out-of-range indices (≥NUM_SIGNALS, possible when NUM_SIGNALS is not a power of 2) decode to all-zero; oh_valid still asserts for the dwell.
- in_index and in_dwell are sampled only on accept. Changes while busy are ignored.
- Reset mid-operation: one_hot clears immediately (asynchronous) and the FSM returns to IDLE. A pending in_valid is not auto-accepted until after reset deasserts.

Optional Feature:
- Macro: OH_SEL_DRIVER_RANGE_CHK_EN.
- Defined:
  - An accepted in_index ≥ NUM_SIGNALS sets err_oor on the following edge. err_oor is sticky until reset.
  - The command is dropped: FSM stays in IDLE, one_hot stays 0, oh_valid stays 0.
  - Simulation-only assertion fires.
- Undefined: err_oor tied 0; out-of-range behaves as described in Behaviour (all-zero for the dwell).

Decomposition:
- Package oh_pkg:
  - typedef enum logic [1:0] {OHS_IDLE, OHS_DRIVE, OHS_GAP} oh_sel_state_t;
  - string constants OH_DIR_LSB0 / OH_DIR_MSB0.
- Sub-module idx_to_oh: combinational index→one-hot decoder with parameters NUM_SIGNALS and DIRECTION, shared with other blocks. oh_sel_driver instantiates it on the input path ahead of the one_hot register.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> one_hot=4'b0000, oh_valid=0, busy=0, in_ready=1.
- Basic LSB0 (GAP_CYCLES=1): index=2, dwell=3 accepted at T -> one_hot=4'b0100 for T+1..T+3, 4'b0000 at T+4, in_ready=1 at T+5.
- MSB0 with dwell=0: index=0, dwell=0 -> one_hot=4'b1000 for exactly 1 cycle, then gap.
- Back-to-back (GAP_CYCLES=0): stream index 1 then 3, dwell=2, in_valid held -> 0010,0010,1000,1000. No zero cycle between; in_ready high only in the last DRIVE cycle.
- Out of range (NUM_SIGNALS=5, index=6):
  - with OH_SEL_DRIVER_RANGE_CHK_EN: err_oor=1 next cycle, one_hot stays 0, FSM in IDLE;
  - without: err_oor=0, one_hot=0, oh_valid=1 for the dwell.
- Async reset mid-DRIVE: rst_n falls between edges during dwell=10 -> one_hot=0 immediately, busy=0 after release, new command accepted normally.
